// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: run/pause/adjust FSM that emits
// one-cycle inc/clr/ld pulses and the adjust-mode blink mask.
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_reset,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic       inc,
  output logic       clr,
  output logic       ld,
  output logic [1:0] ld_sel,
  output logic [3:0] ld_val,
  output logic [3:0] blank,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } st_t;

  st_t        cur;
  st_t        nxt;
  logic       prev_rst;
  logic       prev_pse;
  logic       blink;
  logic       pend;
  logic [1:0] sel_h;
  logic [3:0] num_h;

  logic       rp;
  logic       pp;
  logic       chg;
  logic       clr_n;
  logic       want_ld;
  logic       blink_n;
  logic [3:0] cval;
  logic [3:0] mask;

  assign rp    = btn_reset & ~prev_rst;
  assign pp    = btn_pause & ~prev_pse;
  assign chg   = (sel != sel_h) || (num != num_h);
  assign mask  = 4'b0001 << sel;
  assign state = cur;

  // Tens digits (odd sel) only count to 5.
  always_comb begin
    cval = num;
    if (sel[0]) begin
      if (num > 4'd5) cval = 4'd5;
    end else begin
      if (num > 4'd9) cval = 4'd9;
    end
  end

  always_comb begin
    nxt   = cur;
    clr_n = 1'b0;
    unique case (cur)
      IDLE: begin
        if (rp)       clr_n = 1'b1;
        else if (adj) nxt = ADJUST;
        else if (pp)  nxt = RUN;
      end
      RUN: begin
        if (rp) begin
          clr_n = 1'b1;
          nxt   = IDLE;
        end
        else if (adj) nxt = ADJUST;
        else if (pp)  nxt = PAUSE;
      end
      PAUSE: begin
        if (rp) begin
          clr_n = 1'b1;
          nxt   = IDLE;
        end
        else if (adj) nxt = ADJUST;
        else if (pp)  nxt = RUN;
      end
      ADJUST: begin
        if (rp)        clr_n = 1'b1;
        else if (!adj) nxt = PAUSE;
      end
    endcase
  end

  // A pending (deferred) load is dropped if adjust mode is left.
  assign want_ld = (nxt == ADJUST) &&
                   (cur != ADJUST || chg || pend);

  assign blink_n = (nxt == ADJUST && cur == ADJUST) ?
                   (blink ^ tick_2hz) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= IDLE;
      inc      <= 1'b0;
      clr      <= 1'b0;
      ld       <= 1'b0;
      ld_sel   <= 2'd0;
      ld_val   <= 4'd0;
      blank    <= 4'd0;
      blink    <= 1'b0;
      pend     <= 1'b0;
      prev_rst <= 1'b1;
      prev_pse <= 1'b1;
      sel_h    <= 2'd0;
      num_h    <= 4'd0;
    end else begin
      cur      <= nxt;
      inc      <= (cur == RUN) & tick_1hz;
      clr      <= clr_n;
      ld       <= want_ld & ~clr_n;
      pend     <= want_ld & clr_n;
      if (want_ld && (chg || cur != ADJUST)) begin
        ld_sel <= sel;
        ld_val <= cval;
      end
      blink    <= blink_n;
      blank    <= blink_n ? mask : 4'd0;
      prev_rst <= btn_reset;
      prev_pse <= btn_pause;
      sel_h    <= sel;
      num_h    <= num;
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller for the stopwatch. It turns debounced button levels, adjust switches and divider ticks into single-cycle command pulses for the BCD counter: increment, clear and digit load. It also drives the adjust-mode blink mask for the display. It sits between the debouncers/clock divider and the counter/display, and replaces the ad-hoc pause/adjust glue in the top level.

## Interface
- No parameters.
- clk  in  1  system clock (100 MHz board clock)
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle strobe from clock divider, 1 Hz
- tick_2hz  in  1  one-cycle strobe, 2 Hz (blink rate)
- btn_reset  in  1  debounced reset-button level
- btn_pause  in  1  debounced center-button level
- adj  in  1  adjust-mode switch level
- sel  in  2  digit select: 0 sec_r, 1 sec_l, 2 min_r, 3 min_l
- num  in  4  requested digit value
- inc  out  1  one-cycle pulse: counter advances one second
- clr  out  1  one-cycle pulse: counter clears to 00:00
- ld  out  1  one-cycle pulse: counter loads ld_val into digit ld_sel
- ld_sel  out  2  digit index for ld
- ld_val  out  4  clamped digit value for ld
- blank  out  4  per-digit blank mask for display, bit i = digit sel i
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 ADJUST

## Operation
- Button edges: btn_reset and btn_pause are edge-detected internally. press = level & ~prev. prev registers reset to 1, so a button held through reset does not fire.
- Event priority in one cycle: rst > reset press > adj level > pause press.
- IDLE: pause press -> RUN; adj=1 -> ADJUST; reset press -> clr, stay IDLE.
- RUN: tick_1hz -> inc; pause press -> PAUSE; reset press -> clr, IDLE; adj=1 -> ADJUST.
- PAUSE: pause press -> RUN; reset press -> clr, IDLE; adj=1 -> ADJUST.
- ADJUST: pause press ignored; reset press -> clr, stay ADJUST; adj=0 -> PAUSE (never directly to RUN).
- inc is decided from the state in the tick cycle. A tick coincident with a pause press in RUN still produces inc. A tick in the cycle RUN is entered does not.
- Load generation in ADJUST: ld pulses once on entry to ADJUST and once per cycle in which sel or num differs from its previous sampled value. No ld outside ADJUST.
- Clamp: ld_val = min(num, 5) for sel 1 and 3; min(num, 9) for sel 0 and 2. ld_sel = sel sampled in the same cycle.
- A clr and ld that would coincide: clr issues that cycle and ld is deferred one cycle.
- Blink: blink flop cleared on ADJUST entry and toggles on each tick_2hz while in ADJUST. blank = blink ? onehot(sel) : 4'b0000. blank = 0 outside ADJUST.

## Timing
- All outputs are registered. Response appears one cycle after the causing input cycle.
- inc, clr, ld are exactly one cycle wide and never asserted two consecutive cycles from one event.
- Reset values: state=IDLE, inc=0, clr=0, ld=0, ld_sel=0, ld_val=0, blank=0, blink=0, edge prev=1, sel/num history=0.
- Assertion of rst mid-operation, including during a deferred ld, drops every pending pulse. The counter is not cleared by rst alone.
- Minimum press spacing: none. Back-to-back edges one cycle apart each act.

## Test plan
- Reset, pause press, 3 tick_1hz strobes, pause press, 2 more ticks -> state IDLE->RUN->PAUSE, exactly 3 inc pulses, each 1 cycle after its tick.
- In RUN, tick_1hz and pause press in the same cycle -> one inc and state PAUSE on the following cycle. Reset press in PAUSE -> clr pulse, state IDLE.
- adj=1 with sel=1, num=8 -> ADJUST, ld with ld_sel=1, ld_val=5. Change sel to 0 -> ld_sel=0, ld_val=8. Change num to 12 -> ld_val=9.
- In ADJUST, 4 tick_2hz strobes with sel=2 -> blank toggles 0100/0000 twice. adj=0 -> state PAUSE, blank=0000.
- Reset press and num change in the same ADJUST cycle -> clr next cycle, ld the cycle after, state stays ADJUST.
- Hold btn_pause=1 across rst deassert -> no state change. Release, then press again -> RUN.
